// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b types: memory word, cache line, line offset width.
// Also the arbiter state encoding and a line-alignment helper.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_line;

  localparam int lc3b_line_offset_width = 4;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  function automatic lc3b_word line_align(input lc3b_word a);
    return {a[15:lc3b_line_offset_width],
            {lc3b_line_offset_width{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM: IDLE/SERVE_I/SERVE_D with round-robin last_grant.
// Ports: i_req, d_req, pmem_resp in; grant_i, grant_d, load, serve_i, serve_d out.
module arbiter_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic d_req,
  input  logic pmem_resp,
  output logic grant_i,
  output logic grant_d,
  output logic load,
  output logic serve_i,
  output logic serve_d
);

  arb_state_t state, next;
  // 1 = D-cache won the most recent grant
  logic last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= next;
      if (load) last_d <= grant_d;
    end
  end

  always_comb begin
    next    = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          i_req & d_req: begin
            grant_d = ~last_d;
            grant_i = last_d;
          end
          d_req & ~i_req: grant_d = 1'b1;
          i_req & ~d_req: grant_i = 1'b1;
          default: ;
        endcase
        load = i_req | d_req;
        if (grant_i) next = SERVE_I;
        else if (grant_d) next = SERVE_D;
      end
      SERVE_I: begin
        grant_i = 1'b1;
        if (pmem_resp) next = IDLE;
      end
      SERVE_D: begin
        grant_d = 1'b1;
        if (pmem_resp) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign serve_i = (state == SERVE_I);
  assign serve_d = (state == SERVE_D);

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line traffic onto one pmem port.
// Ports: icache_*/dcache_* client sides, pmem_* memory side, clk, rst_n.
module cache_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     icache_pmem_read,
  input  lc3b_word icache_pmem_address,
  output logic     icache_pmem_resp,
  output lc3b_line icache_pmem_rdata,
  input  logic     dcache_pmem_read,
  input  logic     dcache_pmem_write,
  input  lc3b_word dcache_pmem_address,
  input  lc3b_line dcache_pmem_wdata,
  output logic     dcache_pmem_resp,
  output lc3b_line dcache_pmem_rdata,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  logic     pmem_resp,
  input  lc3b_line pmem_rdata
);

  logic grant_i, grant_d, load;
  logic serve_i, serve_d, done;

  arbiter_control u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (icache_pmem_read),
    .d_req     (dcache_pmem_read | dcache_pmem_write),
    .pmem_resp (pmem_resp),
    .grant_i   (grant_i),
    .grant_d   (grant_d),
    .load      (load),
    .serve_i   (serve_i),
    .serve_d   (serve_d)
  );

  assign done = (serve_i | serve_d) & pmem_resp;

  // Write wins when the D-cache raises read and write together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else if (load) begin
      pmem_address <= line_align(grant_d ? dcache_pmem_address
                                         : icache_pmem_address);
      pmem_wdata   <= dcache_pmem_wdata;
      pmem_write   <= grant_d & dcache_pmem_write;
      pmem_read    <= grant_i | (grant_d & ~dcache_pmem_write);
    end else if (done) begin
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end
  end

  assign icache_pmem_resp  = serve_i & pmem_resp;
  assign dcache_pmem_resp  = serve_d & pmem_resp;
  assign icache_pmem_rdata = icache_pmem_resp ? pmem_rdata : '0;
  assign dcache_pmem_rdata = dcache_pmem_resp ? pmem_rdata : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed cases plus random traffic.
// A transaction-level model is compared against the DUT every cycle.
module tb_cache_arbiter;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic     i_rd = 1'b0;
  lc3b_word i_addr = '0;
  logic     i_resp;
  lc3b_line i_rdata;
  logic     d_rd = 1'b0;
  logic     d_wr = 1'b0;
  lc3b_word d_addr = '0;
  lc3b_line d_wdata = '0;
  logic     d_resp;
  lc3b_line d_rdata;
  logic     pmem_read, pmem_write;
  lc3b_word pmem_address;
  lc3b_line pmem_wdata;
  logic     pmem_resp;
  lc3b_line pmem_rdata;

  cache_arbiter dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache_pmem_read    (i_rd),
    .icache_pmem_address (i_addr),
    .icache_pmem_resp    (i_resp),
    .icache_pmem_rdata   (i_rdata),
    .dcache_pmem_read    (d_rd),
    .dcache_pmem_write   (d_wr),
    .dcache_pmem_address (d_addr),
    .dcache_pmem_wdata   (d_wdata),
    .dcache_pmem_resp    (d_resp),
    .dcache_pmem_rdata   (d_rdata),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_resp           (pmem_resp),
    .pmem_rdata          (pmem_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Transaction-level model: one owner at a time, winner chosen
  // from who asked and who won last.
  logic     m_busy = 0, m_own_d = 0, m_last_d = 0;
  logic     m_rd = 0, m_wr = 0;
  lc3b_word m_addr = '0;
  lc3b_line m_wd = '0;

  wire any_d  = d_rd | d_wr;
  wire pick_d = any_d && (!i_rd || !m_last_d);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_own_d <= 0; m_last_d <= 0;
      m_rd <= 0; m_wr <= 0; m_addr <= '0; m_wd <= '0;
    end else if (m_busy) begin
      if (pmem_resp) begin
        m_busy <= 0; m_rd <= 0; m_wr <= 0;
      end
    end else if (i_rd || any_d) begin
      m_busy   <= 1;
      m_own_d  <= pick_d;
      m_last_d <= pick_d;
      m_addr   <= (pick_d ? d_addr : i_addr) / 16'd16 * 16'd16;
      m_wr     <= pick_d && d_wr;
      m_rd     <= !(pick_d && d_wr);
      m_wd     <= d_wdata;
    end
  end

  task automatic monitor();
    logic ei, ed;
    forever begin
      @(negedge clk);
      ei = m_busy && !m_own_d && pmem_resp;
      ed = m_busy && m_own_d && pmem_resp;
      chk("pmem_read", pmem_read, m_rd);
      chk("pmem_write", pmem_write, m_wr);
      chk("pmem_address", pmem_address, m_addr);
      if (m_wr) chk("pmem_wdata", pmem_wdata, m_wd);
      chk("i_resp", i_resp, ei);
      chk("d_resp", d_resp, ed);
      chk("i_rdata", i_rdata, ei ? pmem_rdata : '0);
      chk("d_rdata", d_rdata, ed ? pmem_rdata : '0);
    end
  endtask

  // Memory: responds a set or random number of cycles after a strobe.
  int       mem_delay = -1;
  bit       mem_fix = 0;
  lc3b_line mem_fix_data = '0;
  bit       stray_en = 0;

  initial begin
    int cnt;
    cnt = -1;
    pmem_resp = 0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 0;
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (pmem_read | pmem_write) begin
        if (cnt < 0)
          cnt = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
        if (cnt == 0) begin
          pmem_resp = 1;
          if (mem_fix) pmem_rdata = mem_fix_data;
          cnt = -1;
        end else cnt--;
      end else begin
        cnt = -1;
        if (stray_en && $urandom_range(0, 5) == 0) pmem_resp = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    i_rd = 0; d_rd = 0; d_wr = 0;
  endtask

  task automatic do_reset();
    idle_all();
    tick();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic wait_strobe(output int n);
    bit hit;
    hit = 0;
    n = 0;
    for (int k = 0; k < 64 && !hit; k++) begin
      @(negedge clk);
      n++;
      hit = pmem_read | pmem_write;
    end
    if (!hit) timeout("strobe");
  endtask

  task automatic wait_resp(input bit d, output int n);
    bit hit;
    hit = 0;
    n = 0;
    for (int k = 0; k < 64 && !hit; k++) begin
      @(negedge clk);
      n++;
      hit = d ? d_resp : i_resp;
    end
    if (!hit) timeout(d ? "d_resp" : "i_resp");
  endtask

  initial begin
    int n, got, seen;
    bit prev, s;
    lc3b_line w;
    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_read", pmem_read, 0);
    chk("rst_write", pmem_write, 0);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_iresp", i_resp, 0);
    chk("rst_drdata", d_rdata, 0);
    tick();
    rst_n = 1;

    // Single I read
    tick();
    mem_fix = 1;
    mem_fix_data = {16{8'hA5}};
    mem_delay = 3;
    i_addr = 16'h1234;
    i_rd = 1;
    wait_strobe(n);
    chk("t1_grant_lat", n, 2);
    chk("t1_read", pmem_read, 1);
    chk("t1_addr", pmem_address, 16'h1230);
    wait_resp(0, n);
    chk("t1_resp_lat", n, 3);
    chk("t1_rdata", i_rdata, {16{8'hA5}});
    chk("t1_dresp", d_resp, 0);
    tick();
    i_rd = 0;
    @(negedge clk);
    chk("t1_pulse", i_resp, 0);
    chk("t1_clear", pmem_read, 0);
    mem_fix = 0;

    // Simultaneous I read / D write from reset
    do_reset();
    mem_delay = 1;
    w = {$urandom, $urandom, $urandom, $urandom};
    i_addr = 16'h0100; i_rd = 1;
    d_addr = 16'h0207; d_wdata = w; d_wr = 1;
    wait_strobe(n);
    chk("t2_dwrite", pmem_write, 1);
    chk("t2_dread", pmem_read, 0);
    chk("t2_daddr", pmem_address, 16'h0200);
    chk("t2_wdata", pmem_wdata, w);
    wait_resp(1, n);
    tick();
    d_wr = 0;
    @(negedge clk);
    chk("t2_gap", pmem_read | pmem_write, 0);
    @(negedge clk);
    chk("t2_iread", pmem_read, 1);
    chk("t2_iaddr", pmem_address, 16'h0100);
    wait_resp(0, n);
    tick();
    i_rd = 0;

    // Continuous conflict: D,I,D,I,D,I
    do_reset();
    mem_delay = -1;
    i_addr = 16'h0300; i_rd = 1;
    d_addr = 16'h0400; d_wr = 1;
    prev = 0;
    got = 0;
    for (int k = 0; k < 200 && got < 6; k++) begin
      @(negedge clk);
      s = pmem_read | pmem_write;
      if (s && !prev) begin
        chk($sformatf("t3_alt%0d", got), pmem_write, (got % 2) == 0);
        got++;
      end
      prev = s;
    end
    if (got < 6) timeout("t3_alt");

    // D read+write together: write only
    do_reset();
    d_addr = 16'h0555; d_rd = 1; d_wr = 1;
    wait_strobe(n);
    chk("t4_write", pmem_write, 1);
    chk("t4_read", pmem_read, 0);
    wait_resp(1, n);
    tick();
    idle_all();

    // Reset mid-transaction
    do_reset();
    mem_delay = 20;
    d_addr = 16'h0660; d_rd = 1;
    wait_strobe(n);
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("t5_read_drop", pmem_read, 0);
    chk("t5_no_dresp", d_resp, 0);
    idle_all();
    tick();
    tick();
    rst_n = 1;
    mem_delay = 1;
    i_addr = 16'h1110; i_rd = 1;
    d_addr = 16'h2220; d_rd = 1;
    wait_strobe(n);
    chk("t5_d_first", pmem_address, 16'h2220);
    wait_resp(1, n);
    tick();
    d_rd = 0;
    wait_resp(0, n);
    tick();
    i_rd = 0;

    // Stray pmem_resp in IDLE
    tick();
    stray_en = 1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (pmem_resp) begin
        seen++;
        chk("t6_iresp", i_resp, 0);
        chk("t6_dresp", d_resp, 0);
        chk("t6_strobe", pmem_read | pmem_write, 0);
      end
    end
    stray_en = 0;
    tick();
    i_addr = 16'h0ABC; i_rd = 1;
    wait_strobe(n);
    chk("t6_grant_lat", n, 2);
    chk("t6_addr", pmem_address, 16'h0AB0);
    wait_resp(0, n);
    tick();
    i_rd = 0;

    // Random traffic
    mem_delay = -1;
    stray_en = 1;
    repeat (3000) begin
      bit is, ds;
      int r;
      @(negedge clk);
      is = i_resp;
      ds = d_resp;
      tick();
      if (i_rd) begin
        if (is || $urandom_range(0, 63) == 0) i_rd = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        i_addr = 16'($urandom);
        i_rd = 1;
      end
      if (d_rd | d_wr) begin
        if (ds || $urandom_range(0, 63) == 0) begin
          d_rd = 0; d_wr = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        r = int'($urandom_range(0, 7));
        d_addr = 16'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
        d_rd = (r < 4) || (r == 7);
        d_wr = (r >= 4);
      end
    end
    idle_all();
    stray_en = 0;
    repeat (30) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
